// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a full_adder, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_c;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic w_fa_sum;
  logic w_fa_cout;

  full_adder u_fa (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_cin  (r_c),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_sa    <= '0;
      r_sb    <= '0;
      r_ss    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StAdd: begin
          r_ss  <= {w_fa_sum, r_ss[WIDTH-1:1]};
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_c   <= w_fa_cout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_sum   <= {w_fa_sum, r_ss[WIDTH-1:1]};
            r_cout  <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // r_c here is the carry into the MSB position.
            r_ovf   <= r_c ^ w_fa_cout;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end
        end
        default: begin
          // StIdle and StDone both accept a new operation.
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_c     <= i_cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StAdd;
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); checks o_ovf when
// SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .o_ovf   (ovf),
`endif
    .o_cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and pass the accepting edge; operands are then scrambled.
  task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
  endtask

  // Edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_ff_01();
    int n;
    start_op(8'hFF, 8'h01, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ff01_busy got %b want 1", busy); end
    wait_done(n);
    checks++; if (n != WIDTH) begin errors++; $display("FAIL ff01_latency got %0d want %0d", n, WIDTH); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL ff01_sum got %h want 00", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ff01_cout got %b want 1", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff01_busy_done got %b want 0", busy); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ff01_ovf got %b want 0", ovf); end
`endif
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ff01_pulse got %b want 0", done); end
    checks++; if (sum !== 8'h00 || cout !== 1'b1) begin
      errors++; $display("FAIL ff01_hold got %h/%b want 00/1", sum, cout);
    end
  endtask

  task automatic test_7f_01();
    int n;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(n);
    checks++; if (n != WIDTH) begin errors++; $display("FAIL 7f01_latency got %0d want %0d", n, WIDTH); end
    checks++; if (sum !== 8'h80) begin errors++; $display("FAIL 7f01_sum got %h want 80", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL 7f01_cout got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL 7f01_ovf got %b want 1", ovf); end
`endif
    step();
  endtask

  task automatic test_a5_5a_cin();
    int n;
    start_op(8'hA5, 8'h5A, 1'b1);
    wait_done(n);
    checks++; if (n != WIDTH) begin errors++; $display("FAIL a55a_latency got %0d want %0d", n, WIDTH); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL a55a_sum got %h want 00", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL a55a_cout got %b want 1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL a55a_ovf got %b want 0", ovf); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(8'h00, 8'h00, 1'b0);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
      if (i == 4) start = 1'b0;
      step();
      if (done) begin n = i; break; end
    end
    checks++; if (n != WIDTH) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", n, WIDTH); end
    checks++; if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL b2b_first_result got %h/%b want 00/0", sum, cout);
    end
    // Still in the DONE cycle: request the next operation immediately.
    start_op(8'h12, 8'h34, 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy, done);
    end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL b2b_held got %h want 00", sum); end
    wait_done(n);
    checks++; if (n + 1 != WIDTH + 1) begin
      errors++; $display("FAIL b2b_period got %0d want %0d", n + 1, WIDTH + 1);
    end
    checks++; if (sum !== 8'h46 || cout !== 1'b0) begin
      errors++; $display("FAIL b2b_second_result got %h/%b want 46/0", sum, cout);
    end
    step();
  endtask

  task automatic test_reset_mid_add();
    int n;
    int pulses;
    start_op(8'hF0, 8'h0F, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got %h want 00", sum); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
    start_op(8'h03, 8'h04, 1'b0);
    wait_done(n);
    checks++; if (n != WIDTH) begin errors++; $display("FAIL after_rst_latency got %0d want %0d", n, WIDTH); end
    checks++; if (sum !== 8'h07 || cout !== 1'b0) begin
      errors++; $display("FAIL after_rst_result got %h/%b want 07/0", sum, cout);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_ff_01();
    test_7f_01();
    test_a5_5a_cin();
    test_back_to_back();
    test_reset_mid_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
